// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, FSM encoding and scancode-to-ASCII map for ps2_key_events
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    localparam int EVT_W         = 18;
    localparam int EVT_BRK_BIT   = 17;
    localparam int EVT_EXT_BIT   = 16;
    localparam int EVT_CODE_LSB  = 8;
    localparam int EVT_ASCII_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    // Keyboard status/ack bytes that must never become key events outside a prefix.
    function automatic logic is_discard(input logic [7:0] code);
        return (code == 8'hE1) || (code == 8'hFA) || (code == 8'hAA) || (code == 8'hEE) ||
               (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);
    endfunction

    function automatic logic [7:0] sc_to_ascii(input logic [7:0] code, input logic ext);
        logic [7:0] a;
        a = 8'h00;
        if (!ext) begin
            case (code)
                8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
                8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
                8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
                8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
                8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
                8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
                8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
                8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33; 8'h25: a = 8'h34;
                8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37; 8'h3E: a = 8'h38;
                8'h46: a = 8'h39; 8'h45: a = 8'h30;
                8'h70: a = 8'h30; 8'h69: a = 8'h31; 8'h72: a = 8'h32; 8'h7A: a = 8'h33;
                8'h6B: a = 8'h34; 8'h73: a = 8'h35; 8'h74: a = 8'h36; 8'h6C: a = 8'h37;
                8'h75: a = 8'h38; 8'h7D: a = 8'h39;
                8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
                default: a = 8'h00;
            endcase
        end
        return a;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - synchronous show-ahead event FIFO with simultaneous push/pop
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] last_q;
    logic             do_pop;
    logic             do_push;

    assign head_valid = (count != '0);
    assign full       = (count == FULL_CNT);
    assign do_pop     = pop && head_valid;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign do_push    = push && (!full || do_pop);
    // Once drained, keep presenting the last word the consumer took.
    assign head_data  = head_valid ? mem[rd_ptr] : last_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_events.sv
// rtl/ps2_key_events.sv - PS/2 scancode stream to queued make/break key events
module ps2_key_events
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [EVT_W-1:0] evt_data,
    output logic             held,
    output logic [7:0]       held_code,
    output logic [7:0]       held_ascii,
    output logic [7:0]       press_cnt,
    output logic             overflow
);

    ps2_state_t       state;
    logic             held_ext;
    logic             is_prefix;
    logic             ext_st;
    logic             brk_st;
    logic             is_key;
    logic             same_key;
    logic             evt_push;
    logic             evt_pop;
    logic             fifo_full;
    logic [7:0]       key_ascii;
    logic [EVT_W-1:0] evt_word;

    always_comb begin
        is_prefix = (in_data == SC_EXT) || (in_data == SC_BRK);
        ext_st    = (state == ST_EXT) || (state == ST_EXT_BRK);
        brk_st    = (state == ST_BRK) || (state == ST_EXT_BRK);
        is_key    = in_valid && !is_prefix && !((state == ST_IDLE) && is_discard(in_data));
        same_key  = held && (in_data == held_code) && (ext_st == held_ext);
        key_ascii = sc_to_ascii(in_data, ext_st);
        // Breaks are always reported; a make of the held key is a typematic repeat.
        evt_push  = is_key && (brk_st || !same_key);
        evt_word  = '0;
        evt_word[EVT_BRK_BIT]                    = brk_st;
        evt_word[EVT_EXT_BIT]                    = ext_st;
        evt_word[EVT_CODE_LSB +: 8]              = in_data;
        evt_word[EVT_ASCII_LSB +: 8]             = key_ascii;
    end

    assign evt_pop = evt_valid && evt_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            held       <= 1'b0;
            held_ext   <= 1'b0;
            held_code  <= 8'h00;
            held_ascii <= 8'h00;
            press_cnt  <= 8'h00;
            overflow   <= 1'b0;
        end else if (in_valid) begin
            if (in_data == SC_EXT) begin
                state <= (state == ST_IDLE || state == ST_EXT) ? ST_EXT : ST_EXT_BRK;
            end else if (in_data == SC_BRK) begin
                state <= (state == ST_IDLE || state == ST_BRK) ? ST_BRK : ST_EXT_BRK;
            end else if (is_key) begin
                state <= ST_IDLE;
                if (brk_st) begin
                    if (same_key) begin
                        held       <= 1'b0;
                        held_ext   <= 1'b0;
                        held_code  <= 8'h00;
                        held_ascii <= 8'h00;
                    end
                end else if (!same_key) begin
                    held       <= 1'b1;
                    held_ext   <= ext_st;
                    held_code  <= in_data;
                    held_ascii <= key_ascii;
                    if (press_cnt[3:0] == 4'd9) begin
                        press_cnt[3:0] <= 4'd0;
                        press_cnt[7:4] <= (press_cnt[7:4] == 4'd9) ? 4'd0 : press_cnt[7:4] + 4'd1;
                    end else begin
                        press_cnt[3:0] <= press_cnt[3:0] + 4'd1;
                    end
                end
            end
            if (evt_push && fifo_full && !evt_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (evt_push),
        .push_data  (evt_word),
        .pop        (evt_pop),
        .head_valid (evt_valid),
        .head_data  (evt_data),
        .full       (fifo_full)
    );

endmodule

// File: doc/ps2_key_events.md
# ps2_key_events

Consumes the raw scancode byte stream from the PS/2 receiver (one strobe per validated frame) and turns it into discrete key events. Resolves E0 (extended) and F0 (break) prefixes, suppresses typematic repeats, tracks the currently held key, and counts key presses in BCD. Events are queued in a small FIFO with a valid/ready output toward the display/CPU-side consumer.

## Interface
- FIFO_DEPTH, 8, event queue depth; power of two, ≥2
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- in_valid  in  1  one-cycle strobe: in_data holds a validated scancode byte
- in_data  in  8  scancode byte from receiver
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head when evt_valid&evt_ready
- evt_data  out  18  {is_break, is_ext, scancode[7:0], ascii[7:0]}
- held  out  1  a key is currently held
- held_code  out  8  scancode of held key (ext flag internal)
- held_ascii  out  8  ASCII of held key, 00 if none/unmapped
- press_cnt  out  8  two BCD digits {tens, ones}, count of new presses
- overflow  out  1  sticky: an event was dropped on a full FIFO

## Operation
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Moves only on in_valid.
- IDLE: E0→EXT; F0→BRK; E1, FA, AA, EE, FE, 00, FF discarded, stay; other→make(ext=0).
- EXT: E0→stay; F0→EXT_BRK; other→make(ext=1), →IDLE.
- BRK: F0→stay; E0→EXT_BRK; other→break(ext=0), →IDLE.
- EXT_BRK: E0/F0→stay; other→break(ext=1), →IDLE.
- Make: if held and {code,ext} equals held key → typematic repeat: no event, no count. Else push make event; held←1, held key←{code,ext}; press_cnt BCD increment, 99→00 wrap.
- Break: always push break event; if {code,ext} equals held key → held←0, held_code/held_ascii←00; else held state unchanged.
- ASCII (ext=0 only; ext=1 → 00): 1C..1A letters a–z at standard set-2 codes (1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z); top-row digits 16,1E,26,25,2E,36,3D,3E,46,45 → '1'..'9','0'; keypad 70,69,72,7A,6B,73,74,6C,75,7D → '0'..'9'; 29→20, 5A→0D, 66→08; else 00. Break events carry the same ASCII as make.
- FIFO full, push requested: event dropped, overflow←1; held/press_cnt still update. Full with simultaneous pop: push accepted.
- Empty: evt_valid=0, evt_data holds last value.

## Timing
- in_valid at edge t → state, held*, press_cnt updated at edge t+1; event visible on evt_valid/evt_data at t+1 if FIFO was empty (show-ahead, registered).
- in_valid may assert every cycle; no stall path upstream.
- evt_data stable while evt_valid & !evt_ready. Pop takes effect at the accepting edge; next head visible the following cycle.
- Reset (any time, including mid-prefix): FSM→IDLE, FIFO emptied, evt_valid 0, evt_data 0, held 0, held_code 00, held_ascii 00, press_cnt 00, overflow 0. Pending prefixes and queued events lost.

## Structure
- Package ps2_pkg: prefix constants (E0, F0, discard codes), event field offsets/width (18), FSM state encoding, scancode→ASCII function.
- Sub-module ps2_evt_fifo: synchronous show-ahead FIFO, parameter DEPTH, WIDTH; full/empty, simultaneous push/pop.
- Top holds FSM, held-key register, BCD counter, overflow flag.

## Test plan
- 1C, F0 1C → events {0,0,1C,61}, {1,0,1C,61}; press_cnt 01; held 1 then 0.
- E0 75, E0 F0 75 → {0,1,75,00}, {1,1,75,00}; held_code 75 then 00; press_cnt 01.
- 1C ×5 (typematic) then F0 1C → one make, one break; press_cnt 01.
- evt_ready=0, 10 make/break pairs of distinct keys, DEPTH 8 → first 8 events retained in order, overflow 1, press_cnt 10.
- 100 distinct press/release cycles → press_cnt wraps 99→00; held_ascii tracks 'a'→61 for 1C, '5'→35 for 2E.
- Assert resetn low after E0 F0, then send 1C → make ext=0; all outputs at reset values during reset.
